// File: rtl/xor_tree_pkg.sv
// Shared constants, types and elaboration-time helpers for the pipelined XOR parity tree.
package xor_tree_pkg;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 1296;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 16;
    localparam int REG_MIN      = 1;
    localparam int REG_MAX      = 4;
    localparam int FANIN        = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic v;
        logic sop;
        logic eop;
    } ctrl_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Smallest d with 6^d >= n: the number of 6-input XOR levels needed.
    function automatic int clog6(input int n);
        int     d;
        longint cap;
        d   = 0;
        cap = 1;
        while (cap < longint'(n)) begin
            cap = cap * FANIN;
            d   = d + 1;
        end
        return d;
    endfunction

    function automatic int level_width(input int width, input int lvl);
        int n;
        n = width;
        for (int i = 0; i < lvl; i++) n = ceil_div(n, FANIN);
        return n;
    endfunction

endpackage

// File: rtl/xor_reduce_pipe_if.sv
// Lane data, framing controls and parity results of the XOR reduction pipe.
interface xor_reduce_pipe_if #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4
);
    logic [WIDTH*CHANNELS-1:0] din;
    logic                      din_valid;
    logic                      din_sop;
    logic                      din_eop;
    logic                      err_clr;
    logic [CHANNELS-1:0]       word_par;
    logic                      word_valid;
    logic [CHANNELS-1:0]       acc_par;
    logic                      acc_valid;
    logic                      frame_err;

    modport master (
        output din, din_valid, din_sop, din_eop, err_clr,
        input  word_par, word_valid, acc_par, acc_valid, frame_err
    );

    modport slave (
        input  din, din_valid, din_sop, din_eop, err_clr,
        output word_par, word_valid, acc_par, acc_valid, frame_err
    );
endinterface

// File: rtl/xor6_level.sv
// One combinational level of the parity tree: each output bit is the XOR of six inputs,
// with the last group zero-padded.
module xor6_level
    import xor_tree_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]                in_i,
    output logic [ceil_div(N, 6)-1:0]   out_o
);
    localparam int M = ceil_div(N, FANIN);

    logic [FANIN*M-1:0] padded;

    // NOTE: default the whole vector first so the partial write cannot infer a latch.
    always_comb begin
        padded         = '0;
        padded[N-1:0]  = in_i;
    end

    for (genvar m = 0; m < M; m++) begin : g_node
        assign out_o[m] = ^padded[FANIN*m +: FANIN];
    end

endmodule

// File: rtl/xor_reduce_pipe.sv
// Multi-lane pipelined parity engine with per-packet running parity and sticky framing error.
module xor_reduce_pipe
    import xor_tree_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CHANNELS  = 4,
    parameter int REG_EVERY = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    xor_reduce_pipe_if.slave  bus
);
    localparam int D = clog6(WIDTH);
    localparam int P = ceil_div(D, REG_EVERY);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("xor_reduce_pipe: WIDTH out of range");
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("xor_reduce_pipe: CHANNELS out of range");
    end
    if (REG_EVERY < REG_MIN || REG_EVERY > REG_MAX) begin : g_bad_reg_every
        $error("xor_reduce_pipe: REG_EVERY out of range");
    end

    logic [CHANNELS-1:0] word_par;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        for (genvar l = 1; l <= D; l++) begin : g_lvl
            localparam int NI = level_width(WIDTH, l - 1);
            localparam int NO = level_width(WIDTH, l);

            logic [NI-1:0] lvl_in;
            logic [NO-1:0] lvl_comb;
            logic [NO-1:0] lvl_o;

            if (l == 1) begin : g_first
                assign lvl_in = bus.din[c*WIDTH +: WIDTH];
            end else begin : g_next
                assign lvl_in = g_lvl[l-1].lvl_o;
            end

            xor6_level #(.N(NI)) u_level (
                .in_i  (lvl_in),
                .out_o (lvl_comb)
            );

            if ((l % REG_EVERY) == 0 || l == D) begin : g_reg
                logic [NO-1:0] lvl_q;
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                always_ff @(posedge clk or negedge arst_n) begin
                    if (!arst_n) lvl_q <= '0;
                    else         lvl_q <= lvl_comb;
                end
                assign lvl_o = lvl_q;
            end else begin : g_comb
                assign lvl_o = lvl_comb;
            end
        end

        assign word_par[c] = g_lvl[D].lvl_o[0];
    end

    // Framing qualifiers travel beside the tree so they line up with word_par.
    ctrl_t ctrl_d;
    ctrl_t ctrl_q [P];
    ctrl_t ctrl_out;

    always_comb begin
        ctrl_d.v   = bus.din_valid;
        ctrl_d.sop = bus.din_valid & bus.din_sop;
        ctrl_d.eop = bus.din_valid & bus.din_eop;
    end

    // NOTE: every delay-line stage is reset so in-flight words are dropped, not flushed, on reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < P; i++) ctrl_q[i] <= '0;
        end else begin
            ctrl_q[0] <= ctrl_d;
            for (int i = 1; i < P; i++) ctrl_q[i] <= ctrl_q[i-1];
        end
    end

    assign ctrl_out = ctrl_q[P-1];

    frame_state_e        state_q;
    logic [CHANNELS-1:0] acc_q;
    logic [CHANNELS-1:0] acc_d;
    logic [CHANNELS-1:0] acc_par_q;
    logic                acc_valid_q;
    logic                frame_err_q;

    assign acc_d = acc_q ^ word_par;

    // Error writes come after the clear so a same-cycle error keeps frame_err set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            acc_par_q   <= '0;
            acc_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            if (bus.err_clr) frame_err_q <= 1'b0;
            if (ctrl_out.v) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (ctrl_out.sop) begin
                            acc_q <= word_par;
                            if (ctrl_out.eop) begin
                                acc_par_q   <= word_par;
                                acc_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_PKT;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    ST_PKT: begin
                        if (ctrl_out.sop) begin
                            frame_err_q <= 1'b1;
                            acc_q       <= word_par;
                            if (ctrl_out.eop) begin
                                acc_par_q   <= word_par;
                                acc_valid_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end
                        end else begin
                            acc_q <= acc_d;
                            if (ctrl_out.eop) begin
                                acc_par_q   <= acc_d;
                                acc_valid_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.word_par   = word_par;
    assign bus.word_valid = ctrl_out.v;
    assign bus.acc_par    = acc_par_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_xor_reduce_pipe.sv
// Scoreboard bench for xor_reduce_pipe: directed framing scenarios on the default build
// plus a randomized WIDTH x REG_EVERY sweep checking parity and latency.
module tb_xor_reduce_pipe;
    localparam int W  = 64;
    localparam int CH = 4;
    localparam int RE = 2;
    localparam int P  = 2;
    localparam int EV = 4096;

    logic clk      = 1'b0;
    logic arst_n   = 1'b1;
    logic sw_rst_n = 1'b1;
    bit   mon_en   = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   sw_finished = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sw_width(input int i);
        case (i)
            0:       return 2;
            1:       return 6;
            2:       return 7;
            3:       return 36;
            4:       return 37;
            default: return 1296;
        endcase
    endfunction

    // Levels of a 6-ary tree covering w bits, grouped into registered stages of r levels.
    function automatic int exp_lat(input int w, input int r);
        int d;
        int cap;
        d   = 0;
        cap = 1;
        while (cap < w) begin
            cap = cap * 6;
            d++;
        end
        return (d + r - 1) / r;
    endfunction

    // ---------------- main instance ----------------
    xor_reduce_pipe_if #(.WIDTH(W), .CHANNELS(CH)) m_if ();
    xor_reduce_pipe #(.WIDTH(W), .CHANNELS(CH), .REG_EVERY(RE)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (m_if)
    );

    int              wdue_q[$];
    logic [CH-1:0]   wpar_q[$];
    int              adue_q[$];
    logic [CH-1:0]   apar_q[$];
    bit              set_ev [EV];
    bit              clr_ev [EV];
    bit              in_pkt_m;
    logic [CH-1:0]   acc_m;
    bit              fe_m;

    function automatic logic [CH-1:0] lane_par(input logic [W*CH-1:0] d);
        logic [CH-1:0] p;
        for (int c = 0; c < CH; c++) p[c] = ^d[c*W +: W];
        return p;
    endfunction

    function automatic logic [W*CH-1:0] rand_din();
        logic [W*CH-1:0] d;
        for (int i = 0; i < W*CH/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Called just after a rising edge; applies one cycle of input and records expectations.
    task automatic drive(input logic [W*CH-1:0] d, input bit v, input bit sop, input bit eop, input bit clr);
        bit            err;
        logic [CH-1:0] wp;
        m_if.din       = d;
        m_if.din_valid = v;
        m_if.din_sop   = sop;
        m_if.din_eop   = eop;
        m_if.err_clr   = clr;
        err = 1'b0;
        if (v) begin
            wp = lane_par(d);
            wdue_q.push_back(cyc + P);
            wpar_q.push_back(wp);
            if (sop) begin
                err      = in_pkt_m;
                acc_m    = wp;
                in_pkt_m = 1'b1;
            end else if (in_pkt_m) begin
                acc_m = acc_m ^ wp;
            end else begin
                err = 1'b1;
            end
            if (eop && in_pkt_m) begin
                adue_q.push_back(cyc + P + 1);
                apar_q.push_back(acc_m);
                in_pkt_m = 1'b0;
            end
        end
        if (err && cyc + P + 1 < EV) set_ev[cyc + P + 1] = 1'b1;
        if (clr && cyc + 1 < EV)     clr_ev[cyc + 1] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        arst_n         = 1'b0;
        m_if.din       = '0;
        m_if.din_valid = 1'b0;
        m_if.din_sop   = 1'b0;
        m_if.din_eop   = 1'b0;
        m_if.err_clr   = 1'b0;
        #1;
        check("rst_word_valid", 64'(m_if.word_valid), 64'd0);
        check("rst_word_par",   64'(m_if.word_par),   64'd0);
        check("rst_acc_valid",  64'(m_if.acc_valid),  64'd0);
        check("rst_acc_par",    64'(m_if.acc_par),    64'd0);
        check("rst_frame_err",  64'(m_if.frame_err),  64'd0);
        wdue_q.delete();
        wpar_q.delete();
        adue_q.delete();
        apar_q.delete();
        for (int i = 0; i < EV; i++) begin
            set_ev[i] = 1'b0;
            clr_ev[i] = 1'b0;
        end
        in_pkt_m = 1'b0;
        acc_m    = '0;
        fe_m     = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && arst_n) begin
            if (m_if.word_valid) begin
                if (wdue_q.size() == 0) check("word_unexpected", 64'd1, 64'd0);
                else begin
                    check("word_latency", 64'(cyc), 64'(wdue_q.pop_front()));
                    check("word_par", 64'(m_if.word_par), 64'(wpar_q.pop_front()));
                end
            end else if (wdue_q.size() > 0 && wdue_q[0] <= cyc) begin
                check("word_missing", 64'd0, 64'd1);
                void'(wdue_q.pop_front());
                void'(wpar_q.pop_front());
            end
            if (m_if.acc_valid) begin
                if (adue_q.size() == 0) check("acc_unexpected", 64'd1, 64'd0);
                else begin
                    check("acc_latency", 64'(cyc), 64'(adue_q.pop_front()));
                    check("acc_par", 64'(m_if.acc_par), 64'(apar_q.pop_front()));
                end
            end else if (adue_q.size() > 0 && adue_q[0] <= cyc) begin
                check("acc_missing", 64'd0, 64'd1);
                void'(adue_q.pop_front());
                void'(apar_q.pop_front());
            end
            if (cyc < EV) begin
                if (set_ev[cyc])      fe_m = 1'b1;
                else if (clr_ev[cyc]) fe_m = 1'b0;
            end
            check("frame_err", 64'(m_if.frame_err), 64'(fe_m));
        end
    end

    initial begin
        logic [W*CH-1:0] d;
        bit v, s, e, k;
        m_if.din       = '0;
        m_if.din_valid = 1'b0;
        m_if.din_sop   = 1'b0;
        m_if.din_eop   = 1'b0;
        m_if.err_clr   = 1'b0;
        @(posedge clk);
        #1;
        sw_rst_n = 1'b0;
        apply_reset();
        sw_rst_n = 1'b1;
        mon_en   = 1'b1;
        idle(2);

        // Single unframed word: lane0 = 1 gives parity 4'b0001 and a framing error.
        d = '0;
        d[0] = 1'b1;
        drive(d, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Three-word packet with odd parity on lane0 in every word.
        for (int i = 0; i < 3; i++) begin
            d = rand_din();
            d[W-1:0] = 64'h1;
            drive(d, 1'b1, i == 0, i == 2, 1'b0);
        end
        idle(3);

        // One-word packets: all-ones lane2, then back-to-back every cycle.
        d = rand_din();
        d[2*W +: W] = '1;
        drive(d, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(rand_din(), 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);

        // eop without packet, then err_clr colliding with a sop-in-packet error, then clr alone.
        drive(rand_din(), 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        drive(rand_din(), 1'b1, 1'b1, 1'b0, 1'b0);
        drive(rand_din(), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(P - 1);
        drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drive(rand_din(), 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Reset mid-packet, stray eop, then a clean packet.
        drive(rand_din(), 1'b1, 1'b1, 1'b0, 1'b0);
        drive(rand_din(), 1'b1, 1'b0, 1'b0, 1'b0);
        apply_reset();
        drive(rand_din(), 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(rand_din(), 1'b1, 1'b1, 1'b0, 1'b0);
        drive(rand_din(), 1'b1, 1'b0, 1'b0, 1'b0);
        drive(rand_din(), 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Random traffic with random framing and clears.
        for (int i = 0; i < 300; i++) begin
            v = ($urandom % 4) != 0;
            s = ($urandom % 4) == 0;
            e = ($urandom % 3) == 0;
            k = ($urandom % 16) == 0;
            drive(rand_din(), v, s, e, k);
        end
        idle(P + 4);
        check("word_drain", 64'(wdue_q.size()), 64'd0);
        check("acc_drain",  64'(adue_q.size()), 64'd0);

        for (int t = 0; t < 3000 && sw_finished < 24; t++) @(posedge clk);
        check("sweep_done", 64'(sw_finished), 64'd24);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- parameter sweep ----------------
    for (genvar i = 0; i < 6; i++) begin : g_sw_w
        for (genvar j = 1; j <= 4; j++) begin : g_sw_r
            localparam int SW = sw_width(i);
            localparam int SP = exp_lat(SW, j);

            xor_reduce_pipe_if #(.WIDTH(SW), .CHANNELS(2)) s_if ();
            xor_reduce_pipe #(.WIDTH(SW), .CHANNELS(2), .REG_EVERY(j)) u_dut (
                .clk    (clk),
                .arst_n (sw_rst_n),
                .bus    (s_if)
            );

            int         due_q[$];
            logic [1:0] par_q[$];

            initial begin
                logic [2*SW-1:0] d;
                bit              v;
                s_if.din       = '0;
                s_if.din_valid = 1'b0;
                s_if.din_sop   = 1'b0;
                s_if.din_eop   = 1'b0;
                s_if.err_clr   = 1'b0;
                @(negedge sw_rst_n);
                @(posedge sw_rst_n);
                for (int n = 0; n < 60; n++) begin
                    @(posedge clk);
                    #1;
                    for (int b = 0; b < 2*SW; b++) d[b] = 1'($urandom);
                    v = ($urandom % 4) != 0;
                    s_if.din       = d;
                    s_if.din_valid = v;
                    if (v) begin
                        due_q.push_back(cyc + SP);
                        par_q.push_back({^d[SW +: SW], ^d[0 +: SW]});
                    end
                end
                @(posedge clk);
                #1;
                s_if.din_valid = 1'b0;
                repeat (SP + 3) @(posedge clk);
                #1;
                check($sformatf("sw_w%0d_r%0d_drain", SW, j), 64'(due_q.size()), 64'd0);
                sw_finished++;
            end

            always @(negedge clk) begin
                if (sw_rst_n) begin
                    if (s_if.word_valid) begin
                        if (due_q.size() == 0)
                            check($sformatf("sw_w%0d_r%0d_unexpected", SW, j), 64'd1, 64'd0);
                        else begin
                            check($sformatf("sw_w%0d_r%0d_latency", SW, j), 64'(cyc), 64'(due_q.pop_front()));
                            check($sformatf("sw_w%0d_r%0d_par", SW, j), 64'(s_if.word_par), 64'(par_q.pop_front()));
                        end
                    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                        check($sformatf("sw_w%0d_r%0d_missing", SW, j), 64'd0, 64'd1);
                        void'(due_q.pop_front());
                        void'(par_q.pop_front());
                    end
                end
            end
        end
    end

endmodule
